ddr_rd_burst_engine: RTL and testbench
======================================

Name:
ddr_rd_burst_engine

Overview:
- Consumes the 64-bit read descriptor and start pulse produced by the control interface on ddr_user_clk.
- Fetches the described region from DDR over an AXI4 read-only master port, single outstanding burst at a time.
- Streams the 512-bit data beats to the MAC datapath.
- Returns a stretched done pulse that the control interface re-synchronises and uses to clear its configuration capture.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 512, AXI/MAC data width. Fixed 64 bytes per beat.
- MAX_BURST, 16, maximum beats per AXI burst. Power of two, 1..256.
- DONE_HOLD, 4, number of cycles ddr_to_mac_done is held high.

Ports:
- ddr_user_clk  in  1  single clock for the whole block.
- ddr_user_rst  in  1  asynchronous, active-high reset.
- ddr_to_mac_start  in  1  one-cycle command strobe.
- O_cfg_value_rd_ddr  in  64  descriptor: [63:32] length in bytes, [31:0] byte base address. Sampled when start is high.
- ddr_to_mac_done  out  1  completion pulse, DONE_HOLD cycles wide.
- busy  out  1  high from command accept until done deasserts.
- rd_err  out  1  sticky error flag; cleared by the next accepted command.
- m_axi_araddr  out  ADDR_W  burst start address, 64-byte aligned.
- m_axi_arlen  out  8  beats minus 1.
- m_axi_arsize  out  3  constant 3'b110 (64 bytes).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address ready.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- mac_data  out  DATA_W  beat to MAC.
- mac_valid  out  1  mac_data valid.
- mac_last  out  1  final beat of the whole command.
- mac_ready  in  1  MAC accepts the beat.

Behaviour:
- Reset values: all outputs 0; m_axi_arsize and m_axi_arburst show their constants; FSM in IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse is generated. The AXI slave is expected to be reset with the same reset.
- Command accept: only in IDLE with start=1.
  - addr_reg <= {desc[31:6], 6'b0} (low 6 address bits ignored).
  - beats_rem <= (len + 63) >> 6, computed in 27 bits.
  - rd_err <= 0, busy <= 1.
- Start while not IDLE is ignored; no queueing.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE -> ADDR on accept when beats_rem != 0.
  - IDLE -> DONE on accept when len = 0. No AXI traffic is issued.
  - ADDR: burst size is computed in the same cycle as ADDR is entered (registered).
    - nb = min(beats_rem, MAX_BURST, 64 - addr_reg[11:6]). Bursts never cross a 4 KB boundary.
    - arvalid = 1, araddr = addr_reg, arlen = nb - 1.
    - arvalid holds with stable address and length until arready.
    - On handshake -> DATA. addr_reg += nb*64; beats_rem -= nb; burst_cnt <= nb.
  - DATA: one beat transfers per rvalid & rready cycle; burst_cnt decrements per beat.
    - On the beat where burst_cnt = 1: go to ADDR if beats_rem != 0, else DONE.
    - rlast is not used for control. A mismatch between rlast and burst_cnt = 1 sets rd_err.
  - DONE: ddr_to_mac_done = 1 for exactly DONE_HOLD cycles (counter), then -> IDLE. busy drops in the same cycle as done drops.
- Output stage: a one-entry register between the R channel and the MAC port.
  - m_axi_rready = in DATA & (~mac_valid | mac_ready).
  - On an R beat, mac_data, mac_valid and mac_last load. mac_last = (burst_cnt = 1 & beats_rem = 0).
  - mac_valid clears when mac_ready=1 and no new beat arrives.
  - Latency is 1 cycle from R handshake to mac_valid. Full throughput when mac_ready=1.
  - mac_valid/mac_data stay stable while mac_ready=0.
- DONE is not entered until the output register has drained (mac_valid=0 or the handshake completes).
- Any rresp != 2'b00 sets rd_err. Data is still forwarded and the command completes normally.
- beats_rem is 27 bits, so the maximum length 0xFFFF_FFFF gives 0x400_0000 beats with no overflow.

Test Plan:
- Descriptor {0x0000_0040, 0x0100_0000}, slave zero-wait, mac_ready=1 -> one AR (addr 0x0100_0000, arlen 0); one mac beat with mac_last=1; done high 4 cycles; busy low after.
- Len 1024 at 0x0100_0000 -> single AR with arlen 15; 16 back-to-back mac beats; mac_last on the 16th only.
- Len 3000 at 0x0100_0F00 -> 47 beats as 4 ARs:
  - 0x0100_0F00 arlen 3
  - 0x0100_1000 arlen 15
  - 0x0100_1400 arlen 15
  - 0x0100_1800 arlen 10
- Len 0 -> no arvalid ever; done for 4 cycles; busy for 5 cycles total.
- Len 256 with mac_ready toggling 1/0 every cycle and arready delayed 3 cycles -> 4 beats delivered in order with data stable while stalled; arvalid and address held during the wait.
- Fault and abort handling:
  - rresp=2'b10 on beat 2 -> rd_err=1 and completion still signalled.
  - A second start during busy -> ignored.
  - Reset asserted mid-DATA -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/ddr_rd_burst_engine.sv
// Read-descriptor DMA: one AXI4 INCR burst in flight at a time, beats streamed to the MAC through a one-entry
// register (1-cycle R->MAC latency, full rate when mac_ready=1); mac_ready low stalls rready, done is a DONE_HOLD-cycle pulse.
module ddr_rd_burst_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int MAX_BURST = 16,
  parameter int DONE_HOLD = 4
) (
  input  logic              ddr_user_clk,
  input  logic              ddr_user_rst,
  input  logic              ddr_to_mac_start,
  input  logic [63:0]       O_cfg_value_rd_ddr,
  output logic              ddr_to_mac_done,
  output logic              busy,
  output logic              rd_err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] mac_data,
  output logic              mac_valid,
  output logic              mac_last,
  input  logic              mac_ready
);

  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_reg;
  logic [26:0]       beats_rem;
  logic [8:0]        burst_cnt;
  logic [8:0]        nb_reg;
  logic [HOLD_W-1:0] done_cnt;

  // Burst length limited by remaining beats, MAX_BURST and the distance to the next 4 KB page.
  function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] addr, input logic [26:0] rem);
    logic [8:0] n;
    logic [8:0] to_page;
    to_page = 9'd64 - {3'b000, addr[11:6]};
    n = 9'(MAX_BURST);
    if (to_page < n) n = to_page;
    if (rem < 27'(n)) n = rem[8:0];
    return n;
  endfunction

  logic [32:0]       len_round;
  logic [26:0]       cmd_beats;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0]        nb_cmd;
  logic [8:0]        nb_next;
  logic              beat;
  logic              burst_end;
  logic              unused_desc_lsb;

  assign len_round       = {1'b0, O_cfg_value_rd_ddr[63:32]} + 33'd63;
  assign cmd_beats       = len_round[32:6];
  assign cmd_addr        = ADDR_W'({O_cfg_value_rd_ddr[31:6], 6'b000000});
  assign unused_desc_lsb = ^O_cfg_value_rd_ddr[5:0];
  assign nb_cmd          = burst_beats(cmd_addr, cmd_beats);
  assign nb_next         = burst_beats(addr_reg, beats_rem);

  assign m_axi_arsize  = 3'b110;
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state == DATA) && (burst_cnt != 9'd0) && (!mac_valid || mac_ready);
  assign beat          = m_axi_rvalid && m_axi_rready;
  assign burst_end     = (burst_cnt == 9'd1);

  always_ff @(posedge ddr_user_clk or posedge ddr_user_rst) begin
    if (ddr_user_rst) begin
      state           <= IDLE;
      addr_reg        <= '0;
      beats_rem       <= '0;
      burst_cnt       <= '0;
      nb_reg          <= '0;
      done_cnt        <= '0;
      ddr_to_mac_done <= 1'b0;
      busy            <= 1'b0;
      rd_err          <= 1'b0;
      m_axi_araddr    <= '0;
      m_axi_arlen     <= '0;
      m_axi_arvalid   <= 1'b0;
      mac_data        <= '0;
      mac_valid       <= 1'b0;
      mac_last        <= 1'b0;
    end else begin
      if (beat) begin
        mac_data  <= m_axi_rdata;
        mac_valid <= 1'b1;
        mac_last  <= burst_end && (beats_rem == 27'd0);
      end else if (mac_ready) begin
        mac_valid <= 1'b0;
        mac_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ddr_to_mac_start) begin
            addr_reg  <= cmd_addr;
            beats_rem <= cmd_beats;
            rd_err    <= 1'b0;
            busy      <= 1'b1;
            if (cmd_beats == 27'd0) begin
              state    <= DONE;
              done_cnt <= '0;
            end else begin
              state         <= ADDR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= cmd_addr;
              m_axi_arlen   <= 8'(nb_cmd - 9'd1);
              nb_reg        <= nb_cmd;
            end
          end
        end

        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            addr_reg      <= addr_reg + ADDR_W'({nb_reg, 6'b000000});
            beats_rem     <= beats_rem - {18'd0, nb_reg};
            burst_cnt     <= nb_reg;
            state         <= DATA;
          end
        end

        DATA: begin
          if (beat) begin
            burst_cnt <= burst_cnt - 9'd1;
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != burst_end)) rd_err <= 1'b1;
            if (burst_end && (beats_rem != 27'd0)) begin
              state         <= ADDR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= addr_reg;
              m_axi_arlen   <= 8'(nb_next - 9'd1);
              nb_reg        <= nb_next;
            end
          end else if ((burst_cnt == 9'd0) && (!mac_valid || mac_ready)) begin
            // Last beat already loaded; completion waits for the MAC to take it.
            state    <= DONE;
            done_cnt <= '0;
          end
        end

        DONE: begin
          if (!ddr_to_mac_done) begin
            ddr_to_mac_done <= 1'b1;
            done_cnt        <= HOLD_W'(DONE_HOLD - 1);
          end else if (done_cnt == '0) begin
            ddr_to_mac_done <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            done_cnt <= done_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_burst_engine.sv
// Randomized bench for ddr_rd_burst_engine: AXI read slave, MAC sink and a burst-planning reference model.
module tb_ddr_rd_burst_engine;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 512;
  localparam int MAX_BURST = 16;
  localparam int DONE_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [63:0]       desc;
  logic              done;
  logic              busy;
  logic              rd_err;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] mac_data;
  logic              mac_valid;
  logic              mac_last;
  logic              mac_ready;

  always #5 clk = ~clk;

  ddr_rd_burst_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .DONE_HOLD(DONE_HOLD)) dut (
    .ddr_user_clk(clk), .ddr_user_rst(rst), .ddr_to_mac_start(start), .O_cfg_value_rd_ddr(desc),
    .ddr_to_mac_done(done), .busy(busy), .rd_err(rd_err),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .mac_data(mac_data), .mac_valid(mac_valid), .mac_last(mac_last), .mac_ready(mac_ready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;

  ar_t     exp_ar[$];
  ar_t     ar_log[$];
  beat_t   exp_mac[$];

  int      checks = 0;
  int      passed = 0;
  longint  cur_total_beats = 0;
  longint  slave_beat_cnt = 0;
  int      cfg_err_beat = -1;
  int      cfg_ar_delay = 0;
  int      cfg_r_gap = 0;
  bit      cfg_rlast_drop = 1'b0;
  int      ready_mode = 0;
  int      mac_hs_cnt = 0;
  time     first_hs_t = 0;
  time     last_hs_t = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_wide(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference: split the aligned region into bursts of min(remaining, MAX_BURST, beats left in 4 KB page).
  task automatic plan(input logic [31:0] len, input logic [31:0] base, input int max_n, output longint beats);
    longint unsigned rem, a, nb, page;
    int n;
    beats = ({32'd0, len} + 64'd63) / 64;
    rem   = beats;
    a     = {32'd0, base} & ~64'h3F;
    n     = 0;
    while (rem > 0 && n < max_n) begin
      page = (4096 - (a % 4096)) / 64;
      nb   = rem;
      if (nb > MAX_BURST) nb = MAX_BURST;
      if (nb > page) nb = page;
      exp_ar.push_back('{addr: a[31:0], len: 8'(nb - 1)});
      a   += nb * 64;
      rem -= nb;
      n++;
    end
  endtask

  // AXI read slave.
  initial begin : slave
    int phase, wait_cnt, blen, bidx;
    bit hold;
    ar_t e;
    phase = 0; wait_cnt = 0; blen = 0; bidx = 0; hold = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; hold = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        continue;
      end
      if (phase == 0) begin
        arready = 1'b0; rvalid = 1'b0;
        if (arvalid) begin phase = 1; wait_cnt = cfg_ar_delay; end
      end
      if (phase == 1) begin
        arready = (wait_cnt == 0);
        if (wait_cnt > 0) wait_cnt--;
      end else if (phase == 2) begin
        arready = 1'b0;
        if (!hold && ($urandom_range(0, 99) >= cfg_r_gap)) begin
          hold  = 1'b1;
          rdata = rand_data();
          rresp = (slave_beat_cnt == longint'(cfg_err_beat)) ? 2'b10 : 2'b00;
          rlast = (bidx == blen - 1) && !cfg_rlast_drop;
        end
        rvalid = hold;
      end
      #1;
      if (phase == 1 && arvalid && arready) begin
        ar_log.push_back('{addr: araddr, len: arlen});
        check("arsize", arsize, 3'b110);
        check("arburst", arburst, 2'b01);
        if (exp_ar.size() == 0) begin
          checks++;
          $display("FAIL unexpected AR: got addr 0x%0h len %0d, expected no request", araddr, arlen);
        end else begin
          e = exp_ar.pop_front();
          check("araddr", araddr, e.addr);
          check("arlen", arlen, e.len);
        end
        blen = int'(arlen) + 1; bidx = 0; phase = 2;
      end else if (phase == 2 && rvalid && rready) begin
        exp_mac.push_back('{data: rdata, last: (slave_beat_cnt == cur_total_beats - 1)});
        slave_beat_cnt++;
        bidx++;
        hold = 1'b0;
        if (bidx == blen) phase = 0;
      end
    end
  end

  initial begin : mac_sink
    mac_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       mac_ready = 1'b1;
        1:       mac_ready = ~mac_ready;
        default: mac_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle compare: output-register latency, stall stability and the expected beat stream.
  initial begin : compare
    bit p_rhs, p_stall, p_arstall;
    logic [DATA_W-1:0] p_rdata, p_mdata;
    logic p_mlast;
    logic [31:0] p_araddr;
    logic [7:0] p_arlen;
    beat_t b;
    p_rhs = 0; p_stall = 0; p_arstall = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin p_rhs = 0; p_stall = 0; p_arstall = 0; continue; end
      if (p_rhs) begin
        check("mac_valid one cycle after R beat", mac_valid, 1);
        check_wide("mac_data after R beat", mac_data, p_rdata);
      end
      if (p_stall) begin
        check("mac_valid held in stall", mac_valid, 1);
        check_wide("mac_data held in stall", mac_data, p_mdata);
        check("mac_last held in stall", mac_last, p_mlast);
      end
      if (p_arstall) begin
        check("arvalid held until arready", arvalid, 1);
        check("araddr held", araddr, p_araddr);
        check("arlen held", arlen, p_arlen);
      end
      if (mac_valid && mac_ready) begin
        if (exp_mac.size() == 0) begin
          checks++;
          $display("FAIL unexpected mac beat: got data with last=%0d, expected no beat", mac_last);
        end else begin
          b = exp_mac.pop_front();
          check_wide("mac_data order", mac_data, b.data);
          check("mac_last", mac_last, b.last);
        end
        if (mac_hs_cnt == 0) first_hs_t = $time;
        last_hs_t = $time;
        mac_hs_cnt++;
      end
      p_rhs = rvalid && rready;     p_rdata = rdata;
      p_stall = mac_valid && !mac_ready;  p_mdata = mac_data;  p_mlast = mac_last;
      p_arstall = arvalid && !arready;    p_araddr = araddr;   p_arlen = arlen;
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, " done"}, done, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " rd_err"}, rd_err, 0);
    check({tag, " arvalid"}, arvalid, 0);
    check({tag, " araddr"}, araddr, 0);
    check({tag, " arlen"}, arlen, 0);
    check({tag, " arsize"}, arsize, 3'b110);
    check({tag, " arburst"}, arburst, 2'b01);
    check({tag, " rready"}, rready, 0);
    check({tag, " mac_valid"}, mac_valid, 0);
    check({tag, " mac_last"}, mac_last, 0);
    check_wide({tag, " mac_data"}, mac_data, '0);
  endtask

  task automatic run_cmd(input logic [31:0] len, input logic [31:0] base, input bit tput, input bit dbl);
    longint beats;
    bit exp_err, prev_done, fall_ok;
    int busy_cyc, done_cyc, done_runs, n;
    time done_rise_t;
    plan(len, base, 1 << 20, beats);
    cur_total_beats = beats; slave_beat_cnt = 0; mac_hs_cnt = 0; ar_log.delete();
    exp_err = (cfg_err_beat >= 0 && longint'(cfg_err_beat) < beats) || (cfg_rlast_drop && beats > 0);
    @(negedge clk);
    start = 1'b1; desc = {len, base};
    @(negedge clk);
    start = 1'b0; desc = {$urandom, $urandom};
    #1;
    check("busy after accept", busy, 1);
    check("rd_err cleared on accept", rd_err, 0);
    busy_cyc = 0; done_cyc = 0; done_runs = 0; prev_done = 0; fall_ok = 0; done_rise_t = 0; n = 0;
    while (1) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        if (!prev_done) begin done_runs++; done_rise_t = $time; end
      end
      if (!busy) begin fall_ok = prev_done && !done; break; end
      prev_done = done;
      if (n >= 20000) break;
      n++;
      start = dbl && (n == 3);
      if (dbl && n == 3) desc = {32'd64, 32'h0200_0000};
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    check("command completes", busy, 0);
    check("done pulse width", done_cyc, DONE_HOLD);
    check("single done pulse", done_runs, 1);
    check("busy falls with done", fall_ok, 1);
    check("mac beats delivered", mac_hs_cnt, beats);
    check("all ARs issued", exp_ar.size(), 0);
    check("no beats left over", exp_mac.size(), 0);
    check("rd_err at completion", rd_err, exp_err);
    if (beats > 0) check("done after last mac beat", done_rise_t > last_hs_t, 1);
    if (tput && beats > 0) check("back-to-back beats", (last_hs_t - first_hs_t) / 10, beats - 1);
    if (beats == 0) begin
      check("len0 busy cycles", busy_cyc, 5);
      check("len0 no AR", ar_log.size(), 0);
    end
    exp_ar.delete(); exp_mac.delete();
  endtask

  task automatic defaults();
    cfg_err_beat = -1; cfg_ar_delay = 0; cfg_r_gap = 0; cfg_rlast_drop = 1'b0; ready_mode = 0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint beats;
    int done_seen, n;
    rst = 1'b1; start = 1'b0; desc = '0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_quiet("post-reset");

    defaults();
    run_cmd(32'd64, 32'h0100_0000, 1, 0);
    check("t1 AR count", ar_log.size(), 1);
    if (ar_log.size() == 1) begin
      check("t1 araddr", ar_log[0].addr, 32'h0100_0000);
      check("t1 arlen", ar_log[0].len, 0);
    end

    run_cmd(32'd1024, 32'h0100_0000, 1, 0);
    check("t2 AR count", ar_log.size(), 1);
    if (ar_log.size() == 1) check("t2 arlen", ar_log[0].len, 15);

    run_cmd(32'd3000, 32'h0100_0F00, 0, 0);
    check("t3 AR count", ar_log.size(), 4);
    if (ar_log.size() == 4) begin
      check("t3 ar0 addr", ar_log[0].addr, 32'h0100_0F00); check("t3 ar0 len", ar_log[0].len, 3);
      check("t3 ar1 addr", ar_log[1].addr, 32'h0100_1000); check("t3 ar1 len", ar_log[1].len, 15);
      check("t3 ar2 addr", ar_log[2].addr, 32'h0100_1400); check("t3 ar2 len", ar_log[2].len, 15);
      check("t3 ar3 addr", ar_log[3].addr, 32'h0100_1800); check("t3 ar3 len", ar_log[3].len, 10);
    end

    run_cmd(32'd0, 32'h0100_0000, 0, 0);

    ready_mode = 1; cfg_ar_delay = 3;
    run_cmd(32'd256, 32'h0100_0000, 0, 0);
    defaults();

    cfg_err_beat = 1;
    run_cmd(32'd512, 32'h0100_2000, 0, 0);
    defaults();
    run_cmd(32'd64, 32'h0100_0040, 0, 0);

    cfg_rlast_drop = 1'b1;
    run_cmd(32'd128, 32'h0100_0000, 0, 0);
    defaults();

    run_cmd(32'd1024, 32'h0100_0000, 0, 1);
    @(negedge clk);
    #1;
    check("second start ignored, stays idle", busy, 0);

    for (int i = 0; i < 16; i++) begin
      ready_mode   = int'($urandom_range(0, 2));
      cfg_ar_delay = int'($urandom_range(0, 3));
      cfg_r_gap    = int'($urandom_range(0, 40));
      cfg_err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_cmd(($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3000)), $urandom, 0, 0);
    end
    defaults();

    // Maximum length: must start a full burst (no overflow to zero beats), then abort with reset.
    plan(32'hFFFF_FFFF, 32'h0300_0000, 1, beats);
    check("max-length beat count", beats, 64'h400_0000);
    cur_total_beats = beats; slave_beat_cnt = 0; mac_hs_cnt = 0; ar_log.delete();
    @(negedge clk);
    start = 1'b1; desc = {32'hFFFF_FFFF, 32'h0300_0000};
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 200 && mac_hs_cnt < 3; n++) @(negedge clk);
    check("abort reached data phase", mac_hs_cnt >= 3, 1);
    check("max-length first arlen", (ar_log.size() > 0) ? ar_log[0].len : 8'hFF, 15);
    #1;
    check("rready before abort", rready, 1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ar.delete(); exp_mac.delete();
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("no done or busy after abort", done_seen, 0);

    run_cmd(32'd640, 32'h0100_0FC0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
